// File: rtl/axilite_master_if.sv
// AXI-Lite bus bundle between an initiator (master) and a remote slave.
// No B channel: writes are posted on this link.
interface axilite_master_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
);
    logic                      axi_awvalid;
    logic [ADDR_WIDTH-1:0]     axi_awaddr;
    logic                      axi_awready;
    logic                      axi_wvalid;
    logic [DATA_WIDTH-1:0]     axi_wdata;
    logic [DATA_WIDTH/8-1:0]   axi_wstrb;
    logic                      axi_wready;
    logic                      axi_arvalid;
    logic [ADDR_WIDTH-1:0]     axi_araddr;
    logic                      axi_arready;
    logic                      axi_rvalid;
    logic [DATA_WIDTH-1:0]     axi_rdata;
    logic                      axi_rready;

    modport master (
        output axi_awvalid, axi_awaddr,
        input  axi_awready,
        output axi_wvalid, axi_wdata, axi_wstrb,
        input  axi_wready,
        output axi_arvalid, axi_araddr,
        input  axi_arready,
        input  axi_rvalid, axi_rdata,
        output axi_rready
    );

    modport slave (
        input  axi_awvalid, axi_awaddr,
        output axi_awready,
        input  axi_wvalid, axi_wdata, axi_wstrb,
        output axi_wready,
        input  axi_arvalid, axi_araddr,
        output axi_arready,
        output axi_rvalid, axi_rdata,
        input  axi_rready
    );
endinterface

// File: rtl/axilite_master.sv
// AXI-Lite initiator: turns one-cycle backend write/read requests into AXI-Lite
// transactions, with independent write and read engines and completion pulses.
module axilite_master #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      axi_aclk,
    input  logic                      axi_aresetn,
    axilite_master_if.master          axi,
    input  logic                      bk_wstart,
    input  logic [ADDR_WIDTH-1:0]     bk_waddr,
    input  logic [DATA_WIDTH-1:0]     bk_wdata,
    input  logic [DATA_WIDTH/8-1:0]   bk_wstrb,
    output logic                      bk_wready,
    output logic                      bk_wdone,
    input  logic                      bk_rstart,
    input  logic [ADDR_WIDTH-1:0]     bk_raddr,
    output logic                      bk_rready,
    output logic [DATA_WIDTH-1:0]     bk_rdata,
    output logic                      bk_rdone
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic {
        W_IDLE,
        W_ISSUE
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } r_state_e;

    w_state_e                w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    wdone_q, wdone_d;
    logic                    aw_seen, w_seen;

    r_state_e                r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    rdone_q, rdone_d;

    // Write engine state register.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            w_state_q <= W_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            wdone_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            wdone_q   <= wdone_d;
        end
    end

    // AW and W retire independently; the transfer completes once both have been seen.
    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        wdone_d   = 1'b0;
        aw_seen   = aw_done_q | (awvalid_q & axi.axi_awready);
        w_seen    = w_done_q | (wvalid_q & axi.axi_wready);
        case (w_state_q)
            W_IDLE: begin
                if (bk_wstart) begin
                    awaddr_d  = bk_waddr;
                    wdata_d   = bk_wdata;
                    wstrb_d   = bk_wstrb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    w_state_d = W_ISSUE;
                end
            end
            W_ISSUE: begin
                if (awvalid_q && axi.axi_awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && axi.axi_wready) begin
                    wvalid_d = 1'b0;
                end
                aw_done_d = aw_seen;
                w_done_d  = w_seen;
                if (aw_seen && w_seen) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    wdone_d   = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase
    end

    // Write engine outputs.
    always_comb begin
        bk_wready       = (w_state_q == W_IDLE);
        bk_wdone        = wdone_q;
        axi.axi_awvalid = awvalid_q;
        axi.axi_awaddr  = awaddr_q;
        axi.axi_wvalid  = wvalid_q;
        axi.axi_wdata   = wdata_q;
        axi.axi_wstrb   = wstrb_q;
    end

    // Read engine state register.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state_q <= R_IDLE;
            araddr_q  <= '0;
            rdata_q   <= '0;
            rdone_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            araddr_q  <= araddr_d;
            rdata_q   <= rdata_d;
            rdone_q   <= rdone_d;
        end
    end

    // Read sequencing: address phase, then data phase; rvalid outside R_DATA is ignored.
    always_comb begin
        r_state_d = r_state_q;
        araddr_d  = araddr_q;
        rdata_d   = rdata_q;
        rdone_d   = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (bk_rstart) begin
                    araddr_d  = bk_raddr;
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (axi.axi_arready) begin
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (axi.axi_rvalid) begin
                    rdata_d   = axi.axi_rdata;
                    rdone_d   = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
    end

    // Read engine outputs.
    always_comb begin
        bk_rready       = (r_state_q == R_IDLE);
        bk_rdone        = rdone_q;
        bk_rdata        = rdata_q;
        axi.axi_arvalid = (r_state_q == R_ADDR);
        axi.axi_araddr  = araddr_q;
        axi.axi_rready  = (r_state_q == R_DATA);
    end
endmodule

// File: doc/axilite_master.md
Name: axilite_master

Overview:
- Initiator-side counterpart of the AXI-Lite slave bridge: converts single-cycle backend write/read requests into AXI-Lite master transactions.
- Returns completion pulses to the backend, and read data for reads.
- Sits on the requesting side of the axilite_axis path, facing a remote AXI-Lite slave.
- Posted writes only: no B channel, consistent with the slave side.

Parameters:
ADDR_WIDTH, 15, width of awaddr/araddr and backend addresses
DATA_WIDTH, 32, width of wdata/rdata and backend data (multiple of 8)

Ports:
axi_aclk  in  1  clock
axi_aresetn  in  1  reset, asynchronous, active-low
axi_awvalid  out  1  write address valid
axi_awaddr  out  ADDR_WIDTH  write address
axi_awready  in  1  write address ready
axi_wvalid  out  1  write data valid
axi_wdata  out  DATA_WIDTH  write data
axi_wstrb  out  DATA_WIDTH/8  write strobes
axi_wready  in  1  write data ready
axi_arvalid  out  1  read address valid
axi_araddr  out  ADDR_WIDTH  read address
axi_arready  in  1  read address ready
axi_rvalid  in  1  read data valid
axi_rdata  in  DATA_WIDTH  read data
axi_rready  out  1  read data ready
bk_wstart  in  1  one-cycle write request
bk_waddr  in  ADDR_WIDTH  write address, sampled with bk_wstart
bk_wdata  in  DATA_WIDTH  write data, sampled with bk_wstart
bk_wstrb  in  DATA_WIDTH/8  write strobes, sampled with bk_wstart
bk_wready  out  1  write engine idle; bk_wstart accepted only when high
bk_wdone  out  1  one-cycle pulse, write handshakes complete
bk_rstart  in  1  one-cycle read request
bk_raddr  in  ADDR_WIDTH  read address, sampled with bk_rstart
bk_rready  out  1  read engine idle; bk_rstart accepted only when high
bk_rdata  out  DATA_WIDTH  captured read data, held until next bk_rdone
bk_rdone  out  1  one-cycle pulse, bk_rdata valid

Behaviour:
- Reset values:
  - all AXI valids/rready 0; addr/data/strb outputs 0.
  - bk_wdone = bk_rdone = 0; bk_rdata = 0; bk_wready = bk_rready = 1.
  - Both FSMs go to IDLE.
- Reset mid-transaction aborts immediately (asynchronous); no completion pulse is generated.
- All AXI and backend outputs are registered or decoded from state only; no combinational path from AXI inputs to AXI outputs.
- Write FSM states: W_IDLE, W_ISSUE.
  - W_IDLE: bk_wready=1. bk_wstart captures addr/data/strb into registers, then goes to W_ISSUE.
  - Entering W_ISSUE asserts awvalid and wvalid together on the next cycle.
  - bk_wstart while bk_wready=0 is ignored (backend protocol error); it does not corrupt the in-flight transfer.
  - W_ISSUE: AW and W complete independently.
    - awvalid drops the cycle after awvalid&awready; wvalid drops the cycle after wvalid&wready.
    - The order of the two handshakes is arbitrary; they may be simultaneous.
    - Address, data and strobe stay stable while the corresponding valid is high (AXI rule).
  - Once both handshakes are seen (flags aw_done, w_done): next cycle bk_wdone=1 for one cycle, FSM returns to W_IDLE and bk_wready=1 in that same cycle.
  - A new bk_wstart in that same cycle is accepted.
  - Best-case latency: bk_wstart@T, valids@T+1, handshakes@T+1, bk_wdone@T+2.
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: bk_rready=1. bk_rstart captures raddr, then goes to R_ADDR.
  - R_ADDR: arvalid=1, araddr stable. On arvalid&arready, go to R_DATA.
  - R_DATA: rready=1. On rvalid&rready, register rdata into bk_rdata and pulse bk_rdone next cycle; FSM returns to R_IDLE in that cycle.
  - rready is 0 outside R_DATA; rvalid seen outside R_DATA is ignored.
  - Best-case latency: bk_rstart@T, arvalid@T+1, rready@T+2, bk_rdone@T+3.
- Read and write engines are fully independent.
  - Simultaneous bk_wstart and bk_rstart are both accepted.
  - No ordering is enforced between the two channels.
- No timeout: stalled slave ready/valid holds the FSM indefinitely.

Test Plan:
- Write, slave always ready: bk_wstart@T, addr 0x1004, data 0xDEADBEEF, strb 0xF -> awvalid&wvalid@T+1 with those values, bk_wdone@T+2, bk_wready=1@T+2.
- Write, awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle; awvalid held with stable addr for 4 cycles; exactly one bk_wdone, 1 cycle after the AW handshake.
- Read, arready@T+1, rvalid at 2nd R_DATA cycle with 0x12345678 -> rready high only in R_DATA, bk_rdone one cycle with bk_rdata=0x12345678, held afterwards.
- Simultaneous bk_wstart and bk_rstart, then a second bk_wstart while busy -> both first transactions complete; second write ignored (one AW, one W, one bk_wdone).
- Back-to-back writes: new bk_wstart in the bk_wdone cycle -> accepted; two AW and two W handshakes with correct values, two bk_wdone pulses.
- Assert axi_aresetn low while awvalid and arvalid are high -> all valids/rready drop immediately, no bk_wdone/bk_rdone, both ready=1 after release.
